// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner sharing one 7-seg decoder across N_DIG common-anode digits.
// Latency: all outputs registered; a write appears from digit 0 of the frame after the next frame_tick.
// Backpressure: wr_ready low while a write awaits commit. Optional leading-zero blanking: SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [4*N_DIG-1:0] wr_data,
  input  logic [N_DIG-1:0]   wr_dp,
  output logic [3:0]         dec_d,
  output logic               dp,
  output logic [N_DIG-1:0]   an_n,
  output logic               frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;

  // Displayed image (shadow) and the single-entry pending write buffer
  logic [N_DIG-1:0][3:0]  shadow, shadow_nxt, pend;
  logic [N_DIG-1:0]       shadow_dp, shadow_dp_nxt, pend_dp;
  logic                   pend_full, pend_full_nxt;
  logic                   accept, commit;

  // Next values of the registered outputs
  logic [3:0]             dec_nxt;
  logic                   dp_nxt;
  logic [N_DIG-1:0]       an_nxt;
  logic                   ft_nxt;
  logic                   lit;

  // Scan state register: state, digit index and slot counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: walk GUARD then SHOW per slot, advance digit at slot end
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_GUARD;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_GUARD;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == GUARD_LAST) begin
              state_nxt = ST_SHOW;
            end
          end
        end
      endcase
    end
  end

  // Write handshake and frame-boundary commit; while idle, commit right away
  always_comb begin
    accept        = wr_valid && wr_ready;
    commit        = pend_full && ((state == ST_IDLE) || frame_tick);
    shadow_nxt    = shadow;
    shadow_dp_nxt = shadow_dp;
    if (commit) begin
      shadow_nxt    = pend;
      shadow_dp_nxt = pend_dp;
    end
    pend_full_nxt = pend_full;
    if (accept) begin
      pend_full_nxt = 1'b1;
    end else if (commit) begin
      pend_full_nxt = 1'b0;
    end
  end

  // Pending buffer and shadow image registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      pend      <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
    end else begin
      shadow    <= shadow_nxt;
      shadow_dp <= shadow_dp_nxt;
      pend_full <= pend_full_nxt;
      if (accept) begin
        pend    <= wr_data;
        pend_dp <= wr_dp;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [N_DIG-1:0] blank;
  logic             zero_run;

  // Blank digit i (i>0) when it and every higher digit are zero with no decimal point
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      zero_run = zero_run && (shadow_nxt[i] == 4'd0) && !shadow_dp_nxt[i];
      blank[i] = zero_run;
    end
  end

  assign lit = !blank[idx_nxt];
`else
  assign lit = 1'b1;
`endif

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    dec_nxt = 4'd0;
    dp_nxt  = 1'b0;
    an_nxt  = '1;
    ft_nxt  = 1'b0;
    if (state_nxt != ST_IDLE) begin
      dec_nxt = shadow_nxt[idx_nxt];
      dp_nxt  = shadow_dp_nxt[idx_nxt];
      ft_nxt  = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
      if ((state_nxt == ST_SHOW) && lit) begin
        an_nxt[idx_nxt] = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_d      <= 4'd0;
      dp         <= 1'b0;
      an_n       <= '1;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      dec_d      <= dec_nxt;
      dp         <= dp_nxt;
      an_n       <= an_nxt;
      frame_tick <= ft_nxt;
      wr_ready   <= !pend_full_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed, table-driven bench for seg_scan_ctrl (N_DIG=4, SCAN_DIV=8, GUARD=2).
// Outputs are sampled on the falling edge; inputs are driven there too.
// Expected values are hand-written per vector and per sequence.
module tb_seg_scan_ctrl;
  localparam int N_DIG    = 4;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  dec_d;
  logic        dp;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .N_DIG   (N_DIG),
    .SCAN_DIV(SCAN_DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .dec_d     (dec_d),
    .dp        (dp),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpin;
    logic [15:0] exp_dec;  // expected dec_d per slot, slot s at [4s+:4]
    logic [3:0]  exp_dp;   // expected dp per slot
    logic [15:0] exp_an;   // expected an_n during SHOW, slot s at [4s+:4]
  } vec_t;

`ifdef SEG_SCAN_LZB_EN
  localparam logic [15:0] AN_0070 = 16'hFFDE;
  localparam logic [15:0] AN_0000 = 16'hFFFE;
  localparam logic [15:0] AN_0500 = 16'hFBDE;
`else
  localparam logic [15:0] AN_0070 = 16'h7BDE;
  localparam logic [15:0] AN_0000 = 16'h7BDE;
  localparam logic [15:0] AN_0500 = 16'h7BDE;
`endif

  vec_t vecs[5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance until frame_tick is seen high, at most 64 cycles
  task automatic wait_ft(input string tag);
    int k;
    k = 0;
    while (frame_tick !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    n_chk++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_tick got %b within 64 cycles, expected 1", tag, frame_tick);
    end
  endtask

  // Check a whole frame starting at digit 0, cycle 0
  task automatic check_frame(input vec_t v, input int vi);
    logic [3:0] ea;
    for (int s = 0; s < N_DIG; s++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        ea = (c < GUARD) ? 4'hF : v.exp_an[4*s +: 4];
        chk($sformatf("v%0d s%0d c%0d an_n", vi, s, c), 32'(an_n), 32'(ea));
        chk($sformatf("v%0d s%0d c%0d dec_d", vi, s, c), 32'(dec_d), 32'(v.exp_dec[4*s +: 4]));
        chk($sformatf("v%0d s%0d c%0d dp", vi, s, c), 32'(dp), 32'(v.exp_dp[s]));
        chk($sformatf("v%0d s%0d c%0d frame_tick", vi, s, c), 32'(frame_tick),
            32'((s == N_DIG - 1) && (c == SCAN_DIV - 1)));
        tick();
      end
    end
  endtask

  // Write one vector, wait for its commit, then check the following frame
  task automatic apply_vec(input vec_t v, input int vi);
    chk($sformatf("v%0d wr_ready before write", vi), 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = v.data;
    wr_dp    = v.dpin;
    tick();
    chk($sformatf("v%0d wr_ready after accept", vi), 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    wait_ft($sformatf("v%0d commit boundary", vi));
    tick();
    chk($sformatf("v%0d wr_ready after commit", vi), 32'(wr_ready), 32'd1);
    check_frame(v, vi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected to have finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 16'h4321, dpin: 4'b0100, exp_dec: 16'h4321, exp_dp: 4'b0100, exp_an: 16'h7BDE};
    vecs[1] = '{data: 16'h0070, dpin: 4'b0000, exp_dec: 16'h0070, exp_dp: 4'b0000, exp_an: AN_0070};
    vecs[2] = '{data: 16'h0000, dpin: 4'b0000, exp_dec: 16'h0000, exp_dp: 4'b0000, exp_an: AN_0000};
    vecs[3] = '{data: 16'h0500, dpin: 4'b0000, exp_dec: 16'h0500, exp_dp: 4'b0000, exp_an: AN_0500};
    vecs[4] = '{data: 16'h0005, dpin: 4'b1000, exp_dec: 16'h0005, exp_dp: 4'b1000, exp_an: 16'h7BDE};

    rst_n    = 1'b0;
    enable   = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    wr_dp    = 4'h0;

    // Reset held for three cycles with enable high
    tick(); tick(); tick();
    chk("reset an_n", 32'(an_n), 32'hF);
    chk("reset dec_d", 32'(dec_d), 32'h0);
    chk("reset dp", 32'(dp), 32'h0);
    chk("reset wr_ready", 32'(wr_ready), 32'h1);
    chk("reset frame_tick", 32'(frame_tick), 32'h0);

    // First slot after release: 2 guard cycles, 6 lit cycles, then digit 1 guard
    rst_n = 1'b1;
    tick();
    for (int c = 0; c <= SCAN_DIV; c++) begin
      chk($sformatf("post-reset c%0d an_n", c), 32'(an_n),
          (c >= GUARD && c < SCAN_DIV) ? 32'hE : 32'hF);
      tick();
    end
    chk("post-reset digit1 dec_d", 32'(dec_d), 32'h0);

    // Scan order, dp placement, blanking, frame_tick period
    for (int i = 0; i < 5; i++) begin
      apply_vec(vecs[i], i);
    end

    // Mid-frame write with back-pressure; now at digit 0 cycle 0 showing 0005/dp 1000
    for (int k = 0; k < 9; k++) tick();
    wr_valid = 1'b1;
    wr_data  = 16'hABCD;
    wr_dp    = 4'b0000;
    tick();
    chk("commit wr_ready drops", 32'(wr_ready), 32'h0);
    chk("commit old image digit1 an_n", 32'(an_n), 32'hD);
    wr_data = 16'h5555;
    wr_dp   = 4'b0001;
    tick();
    chk("backpressure wr_ready held low", 32'(wr_ready), 32'h0);
    wait_ft("abcd boundary");
    chk("boundary wr_ready still low", 32'(wr_ready), 32'h0);
    chk("boundary old digit3 dec_d", 32'(dec_d), 32'h0);
    chk("boundary old digit3 dp", 32'(dp), 32'h1);
    tick();
    chk("new frame digit0 dec_d", 32'(dec_d), 32'hD);
    chk("new frame digit0 dp", 32'(dp), 32'h0);
    chk("new frame digit0 an_n guard", 32'(an_n), 32'hF);
    chk("wr_ready after abcd commit", 32'(wr_ready), 32'h1);
    tick();
    chk("held write accepted", 32'(wr_ready), 32'h0);
    chk("digit0 dec_d stable", 32'(dec_d), 32'hD);
    wr_valid = 1'b0;
    wait_ft("5555 boundary");
    chk("abcd digit3 dec_d", 32'(dec_d), 32'hA);
    tick();
    chk("5555 digit0 dec_d", 32'(dec_d), 32'h5);
    chk("5555 digit0 dp", 32'(dp), 32'h1);
    chk("wr_ready after 5555 commit", 32'(wr_ready), 32'h1);

    // Enable drop during digit 2 SHOW, then re-enable
    for (int k = 0; k < 19; k++) tick();
    chk("digit2 show an_n", 32'(an_n), 32'hB);
    enable = 1'b0;
    tick();
    chk("disable an_n off", 32'(an_n), 32'hF);
    chk("disable frame_tick", 32'(frame_tick), 32'h0);
    tick();
    chk("idle an_n off", 32'(an_n), 32'hF);

    // Idle commit: write lands the cycle after acceptance
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    wr_dp    = 4'b0000;
    tick();
    chk("idle accept wr_ready", 32'(wr_ready), 32'h0);
    wr_valid = 1'b0;
    tick();
    chk("idle commit wr_ready", 32'(wr_ready), 32'h1);
    enable = 1'b1;
    tick();
    chk("re-enable guard0 an_n", 32'(an_n), 32'hF);
    chk("re-enable digit0 dec_d", 32'(dec_d), 32'h4);
    tick();
    chk("re-enable guard1 an_n", 32'(an_n), 32'hF);
    tick();
    chk("re-enable show an_n", 32'(an_n), 32'hE);

    // Reset mid-handshake discards the pending write
    wr_valid = 1'b1;
    wr_data  = 16'h9999;
    wr_dp    = 4'b1111;
    tick();
    chk("pre-reset accept wr_ready", 32'(wr_ready), 32'h0);
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mid reset wr_ready", 32'(wr_ready), 32'h1);
    chk("mid reset an_n", 32'(an_n), 32'hF);
    chk("mid reset dec_d", 32'(dec_d), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("after reset digit0 dec_d", 32'(dec_d), 32'h0);
    wait_ft("post-reset boundary");
    tick();
    chk("discarded write dec_d", 32'(dec_d), 32'h0);
    chk("discarded write dp", 32'(dp), 32'h0);
    chk("discarded write wr_ready", 32'(wr_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one dec_7seg decoder across N_DIG common-anode digits. It holds a double-buffered digit image and walks one digit per slot. For each digit it drives the decoder nibble, the decimal point and an active-low anode select, with a guard gap that suppresses ghosting. Host writes use a valid/ready handshake and are committed only at frame boundaries, so the display never shows a partially updated image.

Parameters:
N_DIG, 4, number of digits scanned (2..8)
SCAN_DIV, 1000, clock cycles per digit slot; must be > GUARD
GUARD, 2, cycles at the start of each slot with all anodes off; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  scan enable
wr_valid  in  1  host write request
wr_ready  out  1  controller can accept a write
wr_data  in  4*N_DIG  digit nibbles; [3:0] = digit 0 (rightmost)
wr_dp  in  N_DIG  decimal points; bit i = digit i
dec_d  out  4  nibble to dec_7seg d input
dp  out  1  decimal point for the current digit
an_n  out  N_DIG  active-low anode enables, one-hot-low or all ones
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset: one clock, synchronous, rst_n sampled low at a rising edge. Resets to: shadow=0, pending empty, wr_ready=1, state IDLE, idx=0, slot counter=0, dec_d=0, dp=0, an_n=all ones, frame_tick=0. Reset mid-slot or mid-handshake discards any pending write.
- All outputs are registered.
- State IDLE (enable=0):
  - an_n all ones, counters held at 0.
  - A pending write is committed to shadow on the cycle after acceptance.
- Leaving IDLE: on the first cycle with enable=1, go to GUARD with idx=0.
- State GUARD: cycles 0..GUARD-1 of the slot.
  - an_n all ones.
  - dec_d = shadow nibble[idx] and dp = shadow_dp[idx], driven from the first GUARD cycle so the decoder settles.
- State SHOW: cycles GUARD..SCAN_DIV-1 of the slot.
  - an_n bit idx = 0, all other bits = 1.
  - dec_d and dp stable.
- End of slot: at slot counter = SCAN_DIV-1, go to GUARD with idx = idx+1. idx wraps from N_DIG-1 to 0.
- frame_tick: high exactly on the cycle with idx=N_DIG-1 and slot counter=SCAN_DIV-1.
- Commit: at the frame_tick edge, a pending write moves to shadow. Digit 0 of the next frame shows the new data.
- enable deasserted at any point: IDLE on the next cycle, anodes off, idx and counter cleared. Re-enable restarts at digit 0 in GUARD.
- Handshake:
  - A transfer occurs when wr_valid && wr_ready.
  - wr_ready = !pending_full; it drops the cycle after acceptance and rises the cycle after commit.
  - A write accepted on the same cycle as frame_tick is not committed at that edge; it waits for the next boundary.
  - wr_data and wr_dp are sampled only on the transfer cycle.
- Counter widths: $clog2(SCAN_DIV) and $clog2(N_DIG), no overflow beyond the wrap points.

Optional Feature:
SEG_SCAN_LZB_EN: leading-zero blanking.
- Defined: digit i (i>0) is blanked when shadow nibbles i..N_DIG-1 are all 0 and shadow_dp bits i..N_DIG-1 are all 0.
  - A blanked digit keeps an_n all ones through its SHOW phase; timing and frame_tick are unchanged.
  - Digit 0 is never blanked.
- Undefined: every digit is always lit in SHOW; no blanking logic is present.

Test Plan:
Test parameters: N_DIG=4, SCAN_DIV=8, GUARD=2.
- Reset: rst_n=0 for 3 cycles with enable=1 -> an_n=4'b1111, dec_d=0, dp=0, wr_ready=1, frame_tick=0. After release: cycles 0-1 an_n=1111, cycles 2-7 an_n=1110, cycle 8 dec_d=digit1.
- Scan order: write 16'h4321, dp=4'b0100, then observe a full frame -> slots show dec_d 1,2,3,4 with an_n 1110,1101,1011,0111. dp=1 only in slot 2. frame_tick once every 32 cycles.
- Commit timing: write 16'hABCD mid-frame -> wr_ready=0 the next cycle. Old image until frame_tick; digit 0 after the boundary shows D. wr_ready=1 one cycle after commit.
- Back-pressure: hold wr_valid=1 with a second value 16'h5555 while pending is full -> not accepted until wr_ready returns. Committed at the following boundary.
- Enable drop: deassert enable during digit 2 SHOW -> next cycle an_n=1111. Re-enable -> digit 0 GUARD, 2 cycles, then an_n=1110.
- LZB (macro defined): write 16'h0070, dp=0 -> digits 2 and 3 stay an_n=1111 in SHOW; digit 1 (7) and digit 0 (0) are lit. Write 16'h0000 -> only digit 0 is lit.
